// File: rtl/test_sequencer_pkg.sv
// Shared FSM encoding and width helpers for the test sequencer and its counters.
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP,
        S_FIN
    } state_t;

    // Index width never collapses to zero, so a single-unit bank still has a cur_idx bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/test_sequencer_watchdog.sv
// Loadable saturating up-counter; tc flags when the count equals the requested terminal value.
module seq_watchdog
    import test_sequencer_pkg::*;
#(
    parameter int LIMIT = 15,
    parameter int W     = cnt_w(LIMIT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);

    localparam logic [W-1:0] SAT = W'(LIMIT);

    logic [W-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && (count != SAT)) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/test_sequencer.sv
// Runs a bank of method units one at a time in ascending order, collecting a
// pass/fail and timeout bit per unit behind a watchdog, then reports a verdict.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int  N_TESTS  = 4,
    parameter int  ACK_WAIT = 8,
    parameter int  TIMEOUT  = 10000,
    parameter int  GAP      = 2,
    localparam int IDX_W    = idx_w(N_TESTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [N_TESTS-1:0] test_req,
    input  logic [N_TESTS-1:0] test_busy,
    input  logic [N_TESTS-1:0] test_return,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_TESTS-1:0] fail_mask,
    output logic [N_TESTS-1:0] timeout_mask,
    output logic [IDX_W-1:0]   cur_idx
);

    localparam int WD_W      = cnt_w(TIMEOUT);
    localparam int AUX_LIMIT = max_int(ACK_WAIT, GAP);
    localparam int AUX_W     = cnt_w(AUX_LIMIT);

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [AUX_W-1:0] ACK_LAST = AUX_W'(ACK_WAIT - 1);
    localparam logic [AUX_W-1:0] GAP_LAST = AUX_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TESTS - 1);

    state_t state, state_nxt;

    logic             unit_busy;
    logic             unit_ret;
    logic             last_test;
    logic             sample_ret;
    logic             hang;
    logic             test_over;
    logic             move_on;
    logic             advance;
    logic             accept;
    logic             wd_load, wd_en, wd_tc;
    logic             aux_load, aux_en, aux_tc;
    logic [AUX_W-1:0] aux_term;

    // Only the unit under test is ever looked at; the rest of the bank is ignored.
    assign unit_busy = test_busy[cur_idx];
    assign unit_ret  = test_return[cur_idx];
    assign last_test = (cur_idx == LAST_IDX);
    assign accept    = (state == S_IDLE) && start;
    assign test_over = sample_ret || hang;

    // Watchdog spans the whole wait from the cycle after req until completion.
    assign wd_load = (state == S_ISSUE);
    assign wd_en   = (state == S_WAIT_ACK) || (state == S_WAIT_DONE);

    // One counter times both the ack window and the inter-test gap; they never overlap.
    assign aux_load = (state == S_ISSUE) || test_over;
    assign aux_en   = (state == S_WAIT_ACK) || (state == S_GAP);
    assign aux_term = (state == S_GAP) ? GAP_LAST : ACK_LAST;

    seq_watchdog #(
        .LIMIT (TIMEOUT - 1),
        .W     (WD_W)
    ) u_timeout_wd (
        .clk   (clk),
        .reset (reset),
        .load  (wd_load),
        .en    (wd_en),
        .term  (WD_LAST),
        .tc    (wd_tc)
    );

    seq_watchdog #(
        .LIMIT (AUX_LIMIT),
        .W     (AUX_W)
    ) u_aux_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (aux_load),
        .en    (aux_en),
        .term  (aux_term),
        .tc    (aux_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt  = state;
        sample_ret = 1'b0;
        hang       = 1'b0;
        move_on    = 1'b0;
        advance    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Seeing busy is not completion, so the watchdog may still expire here.
                if (unit_busy) begin
                    if (wd_tc) begin
                        hang = 1'b1;
                    end else begin
                        state_nxt = S_WAIT_DONE;
                    end
                end else if (aux_tc) begin
                    sample_ret = 1'b1;
                end else if (wd_tc) begin
                    hang = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!unit_busy) begin
                    sample_ret = 1'b1;
                end else if (wd_tc) begin
                    hang = 1'b1;
                end
            end
            S_GAP: begin
                if (aux_tc) begin
                    move_on = 1'b1;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (test_over) begin
            if (GAP == 0) begin
                move_on = 1'b1;
            end else begin
                state_nxt = S_GAP;
            end
        end

        if (move_on) begin
            if (last_test) begin
                state_nxt = S_FIN;
            end else begin
                state_nxt = S_ISSUE;
                advance   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_idx      <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            if (accept) begin
                cur_idx      <= '0;
                fail_mask    <= '0;
                timeout_mask <= '0;
                busy         <= 1'b1;
                done         <= 1'b0;
                pass         <= 1'b0;
            end
            if (advance) begin
                cur_idx <= cur_idx + IDX_W'(1);
            end
            if (sample_ret) begin
                fail_mask[cur_idx] <= ~unit_ret;
            end
            if (hang) begin
                fail_mask[cur_idx]    <= 1'b1;
                timeout_mask[cur_idx] <= 1'b1;
            end
            if (state == S_FIN) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= ~|fail_mask;
            end
        end
    end

    always_comb begin
        test_req = '0;
        if (state == S_ISSUE) begin
            test_req[cur_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench: behavioural method units, directed vector table, randomized
// runs against a per-test latency model, plus reset-abort and held-start sequences.
module tb_test_sequencer;

    localparam int N_T   = 4;
    localparam int ACK_W = 8;
    localparam int TMO   = 50;
    localparam int GAP_C = 2;
    localparam int MAX_WAIT = 2000;
    localparam logic [7:0] HUNG = 8'hFF;

    typedef struct packed {
        logic [N_T-1:0][7:0] d;
        logic [N_T-1:0][7:0] h;
        logic [N_T-1:0]      r;
        logic [N_T-1:0]      exp_fm;
        logic [N_T-1:0]      exp_tm;
        logic                exp_pass;
        logic [15:0]         exp_cycles;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N_T-1:0] test_req;
    logic [N_T-1:0] test_busy;
    logic [N_T-1:0] test_return;
    logic           busy;
    logic           done;
    logic           pass;
    logic [N_T-1:0] fail_mask;
    logic [N_T-1:0] timeout_mask;
    logic [1:0]     cur_idx;

    int    n_cmp  = 0;
    int    n_fail = 0;
    string tag    = "init";

    vec_t           cur_v;
    int             cyc       = 0;
    int             t_issue   = 0;
    int             active    = -1;
    int             req_multi = 0;
    int             req_log[$];
    logic [N_T-1:0] rb, rr;
    vec_t           vecs[9];

    test_sequencer #(
        .N_TESTS  (N_T),
        .ACK_WAIT (ACK_W),
        .TIMEOUT  (TMO),
        .GAP      (GAP_C)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .test_req     (test_req),
        .test_busy    (test_busy),
        .test_return  (test_return),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_mask    (fail_mask),
        .timeout_mask (timeout_mask),
        .cur_idx      (cur_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", tag, name, act, exp);
        end
    endtask

    // Unit busy in wait-cycle j (0 = first cycle after req): high from d for h cycles.
    function automatic logic unit_busy_at(input int j, input int d, input int h);
        if (h == 0 || j < d) return 1'b0;
        if (h == int'(HUNG)) return 1'b1;
        return (j < d + h) ? 1'b1 : 1'b0;
    endfunction

    // Per-test outcome and duration from the observable rules: completion index,
    // ack fallback, watchdog limit with completion winning ties, fixed issue and gap.
    function automatic vec_t model(input vec_t v);
        vec_t e;
        int   total;
        e      = v;
        total  = 0;
        e.exp_fm = '0;
        e.exp_tm = '0;
        for (int i = 0; i < N_T; i++) begin
            int d      = int'(v.d[i]);
            int h      = int'(v.h[i]);
            int end_at;
            int waited;
            bit seen   = (h != 0) && (d < ACK_W);
            if (!seen)                 end_at = ACK_W - 1;
            else if (h == int'(HUNG))  end_at = 1 << 30;
            else                       end_at = d + h;
            if (end_at > TMO - 1) begin
                e.exp_fm[i] = 1'b1;
                e.exp_tm[i] = 1'b1;
                waited      = TMO;
            end else begin
                e.exp_fm[i] = ~v.r[i];
                waited      = end_at + 1;
            end
            total += 1 + waited + GAP_C;
        end
        e.exp_pass   = (e.exp_fm == '0);
        e.exp_cycles = 16'(total + 1);
        return e;
    endfunction

    function automatic vec_t base_vec();
        vec_t v;
        v = '0;
        for (int i = 0; i < N_T; i++) begin
            v.d[i] = 8'd0;
            v.h[i] = 8'd5;
        end
        v.r          = '1;
        v.exp_pass   = 1'b1;
        v.exp_cycles = 16'd37;
        return v;
    endfunction

    // Behavioural method units: the unit last requested follows its profile, all others babble.
    initial begin
        test_busy   = '0;
        test_return = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if ((^test_req) !== 1'bx && test_req != '0) begin
                if ($countones(test_req) != 1) req_multi++;
                for (int i = 0; i < N_T; i++) begin
                    if (test_req[i]) active = i;
                end
                req_log.push_back(active);
                t_issue = cyc;
            end
            rb = N_T'($urandom);
            rr = N_T'($urandom);
            if (active >= 0) begin
                rb[active] = unit_busy_at(cyc - t_issue - 1, int'(cur_v.d[active]),
                                          int'(cur_v.h[active]));
                rr[active] = cur_v.r[active];
            end
            test_busy   = rb;
            test_return = rr;
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        cur_v = v;
        req_log.delete();
        req_multi = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_on", busy, 1);
        check("done_cleared", done, 0);
        wait_done(n);
        check("done_latency", n, v.exp_cycles);
        check("fail_mask", fail_mask, v.exp_fm);
        check("timeout_mask", timeout_mask, v.exp_tm);
        check("pass", pass, v.exp_pass);
        check("busy_off", busy, 0);
        check("cur_idx_last", cur_idx, N_T - 1);
        check("req_count", req_log.size(), N_T);
        check("req_onehot", req_multi, 0);
        for (int k = 0; k < req_log.size() && k < N_T; k++) begin
            check($sformatf("req_order%0d", k), req_log[k], k);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        cur_v = base_vec();

        repeat (3) @(posedge clk);
        #1;
        tag = "reset";
        check("test_req", test_req, 0);
        check("busy", busy, 0);
        check("done", done, 0);
        check("pass", pass, 0);
        check("fail_mask", fail_mask, 0);
        check("timeout_mask", timeout_mask, 0);
        check("cur_idx", cur_idx, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table; expected verdicts and done latencies worked out by hand.
        vecs[0] = base_vec();
        vecs[1] = base_vec(); vecs[1].r = 4'b1011; vecs[1].exp_fm = 4'b0100; vecs[1].exp_pass = 1'b0;
        vecs[2] = base_vec(); vecs[2].h[1] = HUNG; vecs[2].exp_fm = 4'b0010; vecs[2].exp_tm = 4'b0010;
        vecs[2].exp_pass = 1'b0; vecs[2].exp_cycles = 16'd81;
        vecs[3] = base_vec(); vecs[3].h[0] = 8'd0; vecs[3].exp_cycles = 16'd39;
        vecs[4] = base_vec(); vecs[4].h[3] = 8'd49; vecs[4].exp_cycles = 16'd81;
        vecs[5] = base_vec(); vecs[5].h[3] = 8'd50; vecs[5].exp_fm = 4'b1000; vecs[5].exp_tm = 4'b1000;
        vecs[5].exp_pass = 1'b0; vecs[5].exp_cycles = 16'd81;
        vecs[6] = base_vec();
        for (int i = 0; i < N_T; i++) begin
            vecs[6].d[i] = 8'd3;
            vecs[6].h[i] = 8'd2;
        end
        vecs[6].r = 4'b1110; vecs[6].exp_fm = 4'b0001; vecs[6].exp_pass = 1'b0;
        vecs[7] = base_vec(); vecs[7].d[1] = 8'd7; vecs[7].h[1] = 8'd1; vecs[7].exp_cycles = 16'd40;
        vecs[8] = base_vec(); vecs[8].d[2] = 8'd8; vecs[8].r = 4'b1011; vecs[8].exp_fm = 4'b0100;
        vecs[8].exp_pass = 1'b0; vecs[8].exp_cycles = 16'd39;

        for (int k = 0; k < 9; k++) begin
            tag = $sformatf("vec%0d", k);
            run_vec(vecs[k]);
        end

        // Randomized unit profiles scored against the latency model.
        for (int k = 0; k < 20; k++) begin
            vec_t v;
            v = '0;
            for (int i = 0; i < N_T; i++) begin
                v.d[i] = 8'($urandom_range(0, 9));
                v.h[i] = ($urandom_range(0, 9) == 0) ? HUNG : 8'($urandom_range(0, 55));
            end
            v.r = N_T'($urandom);
            tag = $sformatf("rand%0d", k);
            run_vec(model(v));
        end

        // Reset during unit 1's WAIT_DONE aborts the run outright.
        tag = "reset_mid";
        cur_v = base_vec();
        cur_v.h[1] = 8'd30;
        cur_v.r[0] = 1'b0;
        req_log.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (req_log.size() < 2 && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_unit1", req_log.size(), 2);
        repeat (3) @(posedge clk);
        #1;
        check("pre_fail_mask", fail_mask, 4'b0001);
        check("pre_busy", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("test_req", test_req, 0);
        check("busy", busy, 0);
        check("done", done, 0);
        check("fail_mask", fail_mask, 0);
        check("cur_idx", cur_idx, 0);
        @(negedge clk);
        reset  = 1'b0;
        active = -1;
        repeat (5) @(posedge clk);
        #1;
        check("no_req_after_reset", req_log.size(), 2);
        tag = "after_reset";
        run_vec(base_vec());

        // start held high: ignored mid-run, re-accepted on the IDLE cycle after FIN.
        tag = "held_start";
        cur_v = base_vec();
        req_log.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n);
        check("done_latency", n, 37);
        check("req_count_run1", req_log.size(), N_T);
        @(posedge clk);
        #1;
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("run2_done", done, 1);
        check("req_count_run2", req_log.size(), 2 * N_T);
        check("run2_fail_mask", fail_mask, 0);
        check("run2_pass", pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "time limit");
    end

endmodule
